vga_bounce_painter: RTL

//  Pixel-colour stage directly downstream of VgaController: consumes nextX/nextY/blank_n/vSync_n, drives VGA_R/G/B.

---
 rtl/vga_bounce_painter_if.sv | 24 ++
 rtl/vga_bounce_painter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vga_bounce_painter_if.sv
// Pixel-stream bundle between the VGA timing controller, the bounce painter and its consumer.
// The master drives the pixel lookahead and controls; the slave returns colour and status.
interface vga_bounce_painter_if;
  logic [10:0] nextX;
  logic [9:0]  nextY;
  logic        blank_n;
  logic        vSync_n;
  logic        pauseReq;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic [7:0]  bounceCount;
  logic        paused;

  modport master (
    output nextX, nextY, blank_n, vSync_n, pauseReq,
    input  red, green, blue, bounceCount, paused
  );

  modport slave (
    input  nextX, nextY, blank_n, vSync_n, pauseReq,
    output red, green, blue, bounceCount, paused
  );
endinterface

// File: rtl/vga_bounce_painter.sv
// Bouncing-square painter over a grid background; sprite moves once per frame on vSync_n fall.
// Optional macro BOUNCE_FLASH_EN: sprite flashes red for FLASH_LEN frames after each bounce.
module vga_bounce_painter #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned BOX_SIZE  = 64,
  parameter int unsigned STEP      = 4,
  parameter int unsigned FLASH_LEN = 8
) (
  input logic                 Clock,
  input logic                 Reset_n,
  vga_bounce_painter_if.slave bus
);
  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StPaused = 1'b1;

  localparam logic [11:0] XLimit = 12'(H_ACTIVE);
  localparam logic [11:0] XBox   = 12'(BOX_SIZE);
  localparam logic [11:0] XStep  = 12'(STEP);
  localparam logic [10:0] YLimit = 11'(V_ACTIVE);
  localparam logic [10:0] YBox   = 11'(BOX_SIZE);
  localparam logic [10:0] YStep  = 11'(STEP);

  logic [10:0] box_x_q, box_x_d;
  logic [9:0]  box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d;  // 1 = moving toward 0
  logic        dir_y_q, dir_y_d;
  logic        vs_q;
  logic [0:0]  state_q, state_d;
  logic [7:0]  bounce_cnt_q, bounce_cnt_d;
  logic [7:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic        tick, move, bounce_x, bounce_y;
  logic        in_x, in_y;
  logic [23:0] sprite_rgb;

  assign tick = vs_q & ~bus.vSync_n;
  // Movement is gated by the state before any same-cycle pause toggle.
  assign move = tick && (state_q == StRun);

  always_comb begin
    box_x_d  = box_x_q;
    dir_x_d  = dir_x_q;
    bounce_x = 1'b0;
    if (move) begin
      if (!dir_x_q) begin
        if ({1'b0, box_x_q} + XStep + XBox >= XLimit) begin
          box_x_d  = 11'(H_ACTIVE - BOX_SIZE);
          dir_x_d  = 1'b1;
          bounce_x = 1'b1;
        end else begin
          box_x_d = box_x_q + XStep[10:0];
        end
      end else if ({1'b0, box_x_q} <= XStep) begin
        box_x_d  = '0;
        dir_x_d  = 1'b0;
        bounce_x = 1'b1;
      end else begin
        box_x_d = box_x_q - XStep[10:0];
      end
    end
  end

  always_comb begin
    box_y_d  = box_y_q;
    dir_y_d  = dir_y_q;
    bounce_y = 1'b0;
    if (move) begin
      if (!dir_y_q) begin
        if ({1'b0, box_y_q} + YStep + YBox >= YLimit) begin
          box_y_d  = 10'(V_ACTIVE - BOX_SIZE);
          dir_y_d  = 1'b1;
          bounce_y = 1'b1;
        end else begin
          box_y_d = box_y_q + YStep[9:0];
        end
      end else if ({1'b0, box_y_q} <= YStep) begin
        box_y_d  = '0;
        dir_y_d  = 1'b0;
        bounce_y = 1'b1;
      end else begin
        box_y_d = box_y_q - YStep[9:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    bounce_cnt_d = bounce_cnt_q;
    if (bus.pauseReq) begin
      case (state_q)
        StRun:    state_d = StPaused;
        default:  state_d = StRun;
      endcase
    end
    if (bounce_x || bounce_y) bounce_cnt_d = bounce_cnt_q + 8'd1;
  end

`ifdef BOUNCE_FLASH_EN
  logic [3:0] flash_q, flash_d;

  always_comb begin
    flash_d = flash_q;
    if (move) begin
      if (bounce_x || bounce_y) flash_d = 4'(FLASH_LEN);
      else if (flash_q != 4'd0) flash_d = flash_q - 4'd1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) flash_q <= 4'd0;
    else          flash_q <= flash_d;
  end

  assign sprite_rgb = (flash_q != 4'd0) ? 24'hFF0000 : 24'hFFFFFF;
`else
  assign sprite_rgb = 24'hFFFFFF;
`endif

  assign in_x = ({1'b0, bus.nextX} >= {1'b0, box_x_q}) &&
                ({1'b0, bus.nextX} <  {1'b0, box_x_q} + XBox);
  assign in_y = ({1'b0, bus.nextY} >= {1'b0, box_y_q}) &&
                ({1'b0, bus.nextY} <  {1'b0, box_y_q} + YBox);

  always_comb begin
    {red_d, green_d, blue_d} = 24'h000030;
    if (!bus.blank_n) begin
      {red_d, green_d, blue_d} = 24'h000000;
    end else if (in_x && in_y) begin
      {red_d, green_d, blue_d} = sprite_rgb;
    end else if (bus.nextX[5:0] == 6'd0 || bus.nextY[5:0] == 6'd0) begin
      {red_d, green_d, blue_d} = 24'h404040;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      box_x_q      <= '0;
      box_y_q      <= '0;
      dir_x_q      <= 1'b0;
      dir_y_q      <= 1'b0;
      vs_q         <= 1'b1;
      state_q      <= StRun;
      bounce_cnt_q <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
    end else begin
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      vs_q         <= bus.vSync_n;
      state_q      <= state_d;
      bounce_cnt_q <= bounce_cnt_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
    end
  end

  assign bus.red         = red_q;
  assign bus.green       = green_q;
  assign bus.blue        = blue_q;
  assign bus.bounceCount = bounce_cnt_q;
  assign bus.paused      = (state_q == StPaused);
endmodule
